// File: rtl/pulse_divider_pkg.sv
// Shared definitions for the pulse divider counter blocks: mode encodings,
// one-shot state encoding and a width helper.
package pulse_divider_pkg;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } os_state_e;

    // Smallest n such that 2**n >= value (0 for value <= 1).
    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_divider_tick_counter.sv
// Modulo-limit up counter: counts 0..limit-1 while enabled, flags the
// terminal count combinationally so the parent can act on the wrap edge.
module tick_counter #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [NBITS-1:0] limit_i,
    output logic [NBITS-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [NBITS-1:0] ONE = NBITS'(1);

    logic [NBITS-1:0] count_q;
    logic [NBITS-1:0] count_d;

    assign wrap_o  = (count_q == (limit_i - ONE));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = wrap_o ? '0 : (count_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pulse_divider.sv
// Programmable pulse divider: periodic tick, one-shot tick and square wave
// generation from a shared modulo-P counter.
module pulse_divider
    import pulse_divider_pkg::*;
#(
    parameter int NBITS               = 16,
    parameter int DEFAULT_HALF_PERIOD = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [NBITS-1:0] period_in,
    input  logic             start,
    output logic             Pulse,
    output logic             Square,
    output logic             busy,
    output logic [NBITS-1:0] count
);

    localparam logic [NBITS-1:0] P_RESET = NBITS'(DEFAULT_HALF_PERIOD);

    logic [NBITS-1:0] period_q, period_d;
    mode_e            mode_q, mode_d;
    logic             square_q, square_d;
    os_state_e        state_q;

    mode_e mode_in;
    logic  mode_change;
    logic  clear;
    logic  is_oneshot;
    logic  is_run;
    logic  cnt_en;
    logic  wrap;

    assign mode_in     = mode_e'(mode);
    assign mode_change = (mode_in != mode_q);
    // A load or a mode switch restarts the count from zero with the FSM idle.
    assign clear       = load | mode_change;
    assign is_oneshot  = (mode_q == MODE_ONESHOT);
    assign is_run      = (state_q == ST_RUN);
    assign cnt_en      = enable & (~is_oneshot | is_run);

    tick_counter #(
        .NBITS(NBITS)
    ) u_tick_counter (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (clear),
        .enable_i(cnt_en),
        .limit_i (period_q),
        .count_o (count),
        .wrap_o  (wrap)
    );

    always_comb begin
        period_d = period_q;
        if (load && (period_in != '0)) begin
            period_d = period_in;
        end
        mode_d   = mode_in;
        square_d = square_q;
        if (!clear && enable && wrap && (mode_q == MODE_SQUARE)) begin
            square_d = ~square_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q <= P_RESET;
            mode_q   <= MODE_PERIODIC;
            square_q <= 1'b0;
        end else begin
            period_q <= period_d;
            mode_q   <= mode_d;
            square_q <= square_d;
        end
    end

    // One-shot FSM; only reachable in one-shot mode since clear forces IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (clear) begin
            state_q <= ST_IDLE;
        end else if (enable) begin
            case (state_q)
                ST_IDLE: if (is_oneshot && start) state_q <= ST_RUN;
                ST_RUN:  if (wrap)                state_q <= ST_IDLE;
                default:                          state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = is_run;
    assign Square = square_q;
    assign Pulse  = enable & wrap &
                    ((mode_q == MODE_PERIODIC) | (mode_q == MODE_RESERVED) |
                     (is_oneshot & is_run));

endmodule

// File: tb/tb_pulse_divider.sv
// Randomized and directed stimulus for pulse_divider, checked through an
// expected-value queue filled from a behavioural model of the divider.
module tb_pulse_divider;

  localparam int NBITS = 8;
  localparam int DEF   = 2;
  localparam int EW    = NBITS + 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             load = 1'b0;
  logic [NBITS-1:0] period_in = '0;
  logic             start = 1'b0;
  logic             Pulse;
  logic             Square;
  logic             busy;
  logic [NBITS-1:0] count;

  // clock / reset
  always #5 clk = ~clk;

  pulse_divider #(
    .NBITS(NBITS),
    .DEFAULT_HALF_PERIOD(DEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .load(load),
    .period_in(period_in),
    .start(start),
    .Pulse(Pulse),
    .Square(Square),
    .busy(busy),
    .count(count)
  );

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // behavioural model state
  int m_count;
  int m_p;
  int m_mode;
  bit m_sq;
  bit m_run;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_p = DEF;
    m_mode = 0;
    m_sq = 0;
    m_run = 0;
  endtask

  task automatic push_expect(input bit en);
    bit pulse;
    pulse = en && (m_count == m_p - 1) &&
            (m_mode == 0 || m_mode == 3 || (m_mode == 1 && m_run));
    exp_q.push_back({pulse, m_sq, m_run, NBITS'(m_count)});
  endtask

  task automatic model_next(input bit en, input int md, input bit ld, input int pin, input bit st);
    if (ld) begin
      if (pin != 0) m_p = pin;
      m_count = 0;
      m_run = 0;
      m_mode = md;
    end else if (md != m_mode) begin
      m_count = 0;
      m_run = 0;
      m_mode = md;
    end else if (en) begin
      if (m_mode == 1) begin
        if (!m_run) m_run = st;
        else if (m_count == m_p - 1) begin
          m_run = 0;
          m_count = 0;
        end else m_count++;
      end else begin
        m_count = (m_count + 1) % m_p;
        if (m_count == 0 && m_mode == 2) m_sq = !m_sq;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input bit en, input int md, input bit ld, input int pin, input bit st);
    logic [1:0] md_b;
    md_b = md[1:0];
    @(posedge clk);
    #1;
    reset = 1'b1;
    enable = en;
    mode = md_b;
    load = ld;
    period_in = NBITS'(pin);
    start = st;
    push_expect(en);
    model_next(en, md, ld, pin, st);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      enable = 1'b0;
      load = 1'b0;
      start = 1'b0;
      model_reset();
      push_expect(1'b0);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pulse", int'(Pulse), int'(e[EW-1]));
      check("square", int'(Square), int'(e[EW-2]));
      check("busy", int'(busy), int'(e[EW-3]));
      check("count", int'(count), int'(e[NBITS-1:0]));
    end
  end

  initial begin
    int r_md;
    int r_pin;
    bit r_ld;
    bit r_st;
    bit r_en;
    model_reset();
    hold_reset(2);

    // default period 2, periodic
    repeat (6) drive(1, 0, 0, 0, 0);
    // load 5 mid-count, then a zero load that must keep P
    drive(1, 0, 1, 5, 0);
    repeat (12) drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    repeat (11) drive(1, 0, 0, 0, 0);

    // square with P=3 and an enable gap
    drive(1, 2, 1, 3, 0);
    repeat (10) drive(1, 2, 0, 0, 0);
    repeat (4) drive(0, 2, 0, 0, 0);
    repeat (8) drive(1, 2, 0, 0, 0);

    // one-shot P=4, second start while running
    drive(1, 1, 1, 4, 0);
    repeat (2) drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    repeat (5) drive(1, 1, 0, 0, 0);

    // P=1 in each mode
    drive(1, 0, 1, 1, 0);
    repeat (4) drive(1, 0, 0, 0, 0);
    repeat (5) drive(1, 2, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    repeat (3) drive(1, 1, 0, 0, 0);

    // asynchronous reset in the middle of a one-shot run
    drive(1, 1, 1, 6, 0);
    drive(1, 1, 0, 0, 1);
    repeat (2) drive(1, 1, 0, 0, 0);
    hold_reset(1);
    repeat (2) drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    repeat (4) drive(1, 1, 0, 0, 0);

    // asynchronous reset in the middle of square mode
    drive(1, 2, 1, 3, 0);
    repeat (7) drive(1, 2, 0, 0, 0);
    hold_reset(1);
    repeat (6) drive(1, 0, 0, 0, 0);

    // randomized traffic
    r_md = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) r_md = int'($urandom_range(0, 3));
      r_ld = ($urandom_range(0, 14) == 0);
      r_pin = int'($urandom_range(0, 7));
      r_st = ($urandom_range(0, 5) == 0);
      r_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 99) == 0) hold_reset(1);
      else drive(r_en, r_md, r_ld, r_pin, r_st);
    end

    @(posedge clk);
    @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
